data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Data-memory slave sitting directly downstream of the core's LSU. It accepts one load/store request at a time over the core's request/grant/valid handshake, applies a configurable number of wait states, and then performs a byte-lane-masked write or a full-word read on an internal word-addressed array. Its grant and valid outputs drive the LSU's `memory_begin_signal` and `memory_end_signal` inputs.

## Interface
- `DEPTH_WORDS`, 1024: array size in 32-bit words; power of two.
- `LATENCY`, 2: cycles spent in WAIT, ≥1.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `memory_require` in 1: request valid.
- `memory_write_enable` in 1: 1 = store, 0 = load.
- `memory_byte_enable_map` in 4: store byte lanes; bit i selects bits 8i+7:8i.
- `memory_address` in 32: byte address; bits 1:0 ignored.
- `memory_write_data` in 32: store data, already lane-aligned by the LSU.
- `memory_begin_signal` out 1: grant; one-cycle pulse.
- `memory_end_signal` out 1: response valid; one-cycle pulse.
- `memory_read_data` out 32: load data, valid while `memory_end_signal` is high.
- `memory_error` out 1: present only with `DMEM_BUS_ERR_EN`; qualifies `memory_end_signal`.

## Operation
- FSM states are IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `memory_require` is sampled at a rising edge.
  - If high, the controller latches address, write-enable, byte map and write data, loads `cnt = LATENCY-1`, and goes to WAIT.
- WAIT:
  - `memory_begin_signal` is high in the first WAIT cycle only.
  - `cnt` decrements each cycle.
  - On the edge where `cnt == 0`, the access commits and the FSM goes to RESP.
  - Store commit: bytes with byte-map bit = 1 are written at word index `(addr-BASE_ADDR)>>2`. All other bytes are preserved. A byte map of 4'b0000 completes the handshake and changes nothing.
  - Load commit: the full word is registered into `memory_read_data`.
- RESP:
  - `memory_end_signal` is high for exactly one cycle.
  - If `memory_require` is high at the end of RESP, the next request is latched and the FSM goes straight to WAIT (back-to-back, no IDLE bubble). Otherwise it returns to IDLE.
- Inputs are ignored outside IDLE and RESP. Only the latched copy is used, so the core may change inputs after the grant.
- `memory_read_data` holds its last load value across stores and idle cycles.
- Out-of-range addresses without `DMEM_BUS_ERR_EN`: index = `((addr-BASE_ADDR)>>2) mod DEPTH_WORDS`, i.e. upper bits are dropped (wrap-around).

## Timing
- Reset values: `memory_begin_signal` = 0, `memory_end_signal` = 0, `memory_read_data` = 0, `memory_error` = 0, FSM = IDLE, `cnt` = 0. Array contents are not reset.
- Request sampled at edge E0:
  - grant is high in cycle E0..E0+1;
  - valid is high in cycle E0+LATENCY..E0+LATENCY+1.
- Sustained throughput: one access per `LATENCY+1` cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately.
  - A pending store whose commit edge has not yet occurred is discarded.
  - No valid pulse follows.
- `LATENCY=1`: grant and commit happen in the same WAIT cycle, and valid follows in the next cycle.

## Configuration
- `DMEM_BUS_ERR_EN` defined:
  - The `memory_error` port exists.
  - A request is out of range when `addr < BASE_ADDR` or `addr >= BASE_ADDR + DEPTH_WORDS*4`. Such a request still completes the full handshake.
  - For an out-of-range store, the write is suppressed.
  - For an out-of-range load, `memory_read_data` = 32'hDEAD_BEEF.
  - `memory_error` is high exactly when `memory_end_signal` is high.
- `DMEM_BUS_ERR_EN` undefined: the port is absent, and addressing wraps as described in Operation.

## Structure
- Package `dmem_pkg` contains:
  - the `dmem_state_t` enum (IDLE, WAIT, RESP);
  - `DMEM_ERR_PATTERN` = 32'hDEAD_BEEF;
  - default parameter constants.
- Sub-module `dmem_array`: synchronous single-port RAM with per-byte write enables and registered read. It is instantiated once.
- FSM, counter, request latch and range check live in `data_memory_ctrl`.

## Test plan
- Reset release, then a store with addr 0x10, data 0xA5A5_1234, map 4'b1111 → grant 1 cycle after the request, valid 2 cycles after the grant. Then a load from 0x10 → read data 0xA5A5_1234.
- Word pre-loaded with 0x1122_3344, store data 0xFFFF_FFFF with map 4'b0101 → a later load returns 0x11FF_33FF.
- Request held high continuously over 3 loads → valid pulses spaced `LATENCY+1` cycles apart, with no IDLE cycle between them.
- Reset asserted during WAIT of a store to 0x20 (old value 0) → no valid pulse, and a later load of 0x20 returns 0.
- Address changed right after the grant → the access uses the latched address.
- With `DMEM_BUS_ERR_EN`, load from `BASE_ADDR+DEPTH_WORDS*4` → `memory_error` = 1 with valid, data 0xDEAD_BEEF. Without the macro, the same load returns word 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory slave.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [31:0] DMEM_ERR_PATTERN = 32'hDEAD_BEEF;

    localparam int unsigned DMEM_DEFAULT_DEPTH_WORDS = 1024;
    localparam int unsigned DMEM_DEFAULT_LATENCY     = 2;
    localparam logic [31:0] DMEM_DEFAULT_BASE_ADDR   = 32'h0000_0000;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEFAULT_DEPTH_WORDS,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [3:0]        byte_enable,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] index,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_enable[b]) begin
                    mem[index][8*b +: 8] <= write_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data <= 32'h0;
        end else if (read_enable) begin
            read_data <= mem[index];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// LSU-facing data-memory slave: request latch, wait-state FSM and byte-masked array access.
// Optional bus-error reporting for out-of-range addresses is enabled by DMEM_BUS_ERR_EN.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEFAULT_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DMEM_DEFAULT_LATENCY,
    parameter logic [31:0] BASE_ADDR   = DMEM_DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_require,
    input  logic        memory_write_enable,
    input  logic [3:0]  memory_byte_enable_map,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_data,
    output logic        memory_begin_signal,
    output logic        memory_end_signal,
`ifdef DMEM_BUS_ERR_EN
    output logic        memory_error,
`endif
    output logic [31:0] memory_read_data
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              latch, commit;

    logic [ADDR_W-1:0] idx_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              begin_q, end_q;
    logic [31:0]       ram_rdata;
    logic              oor_q;

    // Word index relative to BASE_ADDR; upper bits drop out, giving wrap-around.
    logic [31:0] offset;
    logic        unused_offset_bits;
    assign offset             = memory_address - BASE_ADDR;
    assign unused_offset_bits = ^{offset[1:0], offset[31:ADDR_W+2]};

`ifdef DMEM_BUS_ERR_EN
    localparam logic [32:0] LIMIT_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    logic oor_in;
    assign oor_in = (memory_address < BASE_ADDR) || ({1'b0, memory_address} >= LIMIT_ADDR);
`else
    logic oor_in;
    assign oor_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memory_require) begin
                    latch   = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (memory_require) begin
                    latch   = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            begin_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            begin_q <= latch;
            end_q   <= commit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            oor_q   <= 1'b0;
        end else if (latch) begin
            idx_q   <= offset[ADDR_W+1:2];
            we_q    <= memory_write_enable;
            be_q    <= memory_byte_enable_map;
            wdata_q <= memory_write_data;
            oor_q   <= oor_in;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .write_enable (commit && we_q && !oor_q),
        .byte_enable  (be_q),
        .read_enable  (commit && !we_q),
        .index        (idx_q),
        .write_data   (wdata_q),
        .read_data    (ram_rdata)
    );

    assign memory_begin_signal = begin_q;
    assign memory_end_signal   = end_q;

`ifdef DMEM_BUS_ERR_EN
    logic load_err_q, err_q;

    // Remembers whether the most recent load faulted so the pattern holds like real data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_err_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= commit && oor_q;
            if (commit && !we_q) begin
                load_err_q <= oor_q;
            end
        end
    end

    assign memory_error     = err_q;
    assign memory_read_data = load_err_q ? DMEM_ERR_PATTERN : ram_rdata;
`else
    logic unused_oor;
    assign unused_oor       = oor_q;
    assign memory_read_data = ram_rdata;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl against a word-array reference model.
module tb_data_memory_ctrl;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam int unsigned LATENCY     = 2;
    localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_require;
    logic        memory_write_enable;
    logic [3:0]  memory_byte_enable_map;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;
    logic        memory_begin_signal;
    logic        memory_end_signal;
    logic [31:0] memory_read_data;
`ifdef DMEM_BUS_ERR_EN
    logic        memory_error;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] model [DEPTH_WORDS];
    logic [31:0] last_load;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .BASE_ADDR   (BASE_ADDR)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .memory_require         (memory_require),
        .memory_write_enable    (memory_write_enable),
        .memory_byte_enable_map (memory_byte_enable_map),
        .memory_address         (memory_address),
        .memory_write_data      (memory_write_data),
        .memory_begin_signal    (memory_begin_signal),
        .memory_end_signal      (memory_end_signal),
`ifdef DMEM_BUS_ERR_EN
        .memory_error           (memory_error),
`endif
        .memory_read_data       (memory_read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return int'((off / 32'd4) % 32'(DEPTH_WORDS));
    endfunction

    function automatic logic out_of_range(input logic [31:0] a);
        longint unsigned lim;
        lim = longint'(BASE_ADDR) + longint'(DEPTH_WORDS) * 4;
        return (a < BASE_ADDR) || (longint'(a) >= lim);
    endfunction

    function automatic logic [31:0] mask_of(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m = m | (32'hFF << (8 * i));
        end
        return m;
    endfunction

    // Issues one request from IDLE or RESP, scrambles inputs after the grant, checks response.
    task automatic access(input logic w, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] d);
        int          n;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] m;
        idx     = idx_of(a);
        exp_err = 1'b0;
`ifdef DMEM_BUS_ERR_EN
        exp_err = out_of_range(a);
`endif
        memory_require         = 1'b1;
        memory_write_enable    = w;
        memory_byte_enable_map = be;
        memory_address         = a;
        memory_write_data      = d;
        @(posedge clk);
        @(negedge clk);
        chk("grant", {31'b0, memory_begin_signal}, 32'd1);
        chk("valid_pulse", {31'b0, memory_end_signal}, 32'd0);
        memory_require         = 1'b0;
        memory_write_enable    = 1'($urandom_range(0, 1));
        memory_byte_enable_map = 4'($urandom);
        memory_address         = $urandom;
        memory_write_data      = $urandom;
        n = 0;
        while (memory_end_signal !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(LATENCY));
        chk("grant_low", {31'b0, memory_begin_signal}, 32'd0);
        if (w) begin
            m = mask_of(be);
            if (!exp_err) model[idx] = (model[idx] & ~m) | (d & m);
            chk("hold", memory_read_data, last_load);
        end else begin
            exp_rd = exp_err ? 32'hDEAD_BEEF : model[idx];
            chk("rdata", memory_read_data, exp_rd);
            last_load = exp_rd;
        end
`ifdef DMEM_BUS_ERR_EN
        chk("err", {31'b0, memory_error}, {31'b0, exp_err});
`endif
    endtask

    initial begin
        int          ends [$];
        int          cyc;
        logic [31:0] cur_addr;
        logic        seen;

        reset                  = 1'b0;
        memory_require         = 1'b0;
        memory_write_enable    = 1'b0;
        memory_byte_enable_map = 4'h0;
        memory_address         = 32'h0;
        memory_write_data      = 32'h0;
        last_load              = 32'h0;
        for (int i = 0; i < int'(DEPTH_WORDS); i++) model[i] = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_begin", {31'b0, memory_begin_signal}, 32'd0);
        chk("rst_end", {31'b0, memory_end_signal}, 32'd0);
        chk("rst_rdata", memory_read_data, 32'h0);
`ifdef DMEM_BUS_ERR_EN
        chk("rst_err", {31'b0, memory_error}, 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Basic store then load.
        access(1'b1, 4'b1111, 32'h10, 32'hA5A5_1234);
        access(1'b0, 4'b0000, 32'h10, 32'h0);
        chk("store_load", memory_read_data, 32'hA5A5_1234);

        // Initialise a small window so every later load has a defined model value.
        for (int i = 0; i < 16; i++) begin
            if (i != 4) access(1'b1, 4'b1111, 32'(i * 4), $urandom);
        end

        // Partial byte map, then an empty byte map that must change nothing.
        access(1'b1, 4'b1111, 32'h30, 32'h1122_3344);
        access(1'b1, 4'b0101, 32'h30, 32'hFFFF_FFFF);
        access(1'b0, 4'b0000, 32'h30, 32'h0);
        chk("byte_map", memory_read_data, 32'h11FF_33FF);
        access(1'b1, 4'b0000, 32'h30, 32'h0000_0000);
        access(1'b0, 4'b0000, 32'h30, 32'h0);
        chk("empty_map", memory_read_data, 32'h11FF_33FF);

        // Back-to-back loads with request held high.
        cur_addr               = 32'h0;
        memory_require         = 1'b1;
        memory_write_enable    = 1'b0;
        memory_byte_enable_map = 4'h0;
        memory_address         = cur_addr;
        cyc                    = 0;
        while (ends.size() < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (memory_end_signal === 1'b1) begin
                chk("b2b_rdata", memory_read_data, model[idx_of(cur_addr)]);
                last_load = model[idx_of(cur_addr)];
                ends.push_back(cyc);
                cur_addr       = cur_addr + 32'd4;
                memory_address = cur_addr;
                if (ends.size() == 3) memory_require = 1'b0;
            end
        end
        memory_require = 1'b0;
        chk("b2b_count", 32'(ends.size()), 32'd3);
        if (ends.size() == 3) begin
            chk("b2b_gap0", 32'(ends[1] - ends[0]), 32'(LATENCY + 1));
            chk("b2b_gap1", 32'(ends[2] - ends[1]), 32'(LATENCY + 1));
        end
        @(negedge clk);

        // Reset during WAIT of a store discards it.
        access(1'b1, 4'b1111, 32'h20, 32'h0);
        memory_require         = 1'b1;
        memory_write_enable    = 1'b1;
        memory_byte_enable_map = 4'b1111;
        memory_address         = 32'h20;
        memory_write_data      = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        chk("rst_grant", {31'b0, memory_begin_signal}, 32'd1);
        reset          = 1'b0;
        memory_require = 1'b0;
        @(negedge clk);
        chk("midrst_begin", {31'b0, memory_begin_signal}, 32'd0);
        last_load = 32'h0;
        reset     = 1'b1;
        seen      = 1'b0;
        repeat (LATENCY + 3) begin
            @(negedge clk);
            if (memory_end_signal !== 1'b0) seen = 1'b1;
        end
        chk("rst_no_valid", {31'b0, seen}, 32'd0);
        access(1'b0, 4'b0000, 32'h20, 32'h0);
        chk("rst_discard", memory_read_data, 32'h0);

        // Randomized mix in the initialised window; low address bits are ignored.
        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 1)), 4'($urandom),
                   32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)), $urandom);
        end

        // One past the top: wraps to word 0, or faults when bus errors are enabled.
        access(1'b0, 4'b0000, BASE_ADDR + 32'(DEPTH_WORDS) * 32'd4, 32'h0);
`ifdef DMEM_BUS_ERR_EN
        chk("oor_pattern", memory_read_data, 32'hDEAD_BEEF);
`else
        chk("wrap_word0", memory_read_data, model[0]);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
